// File: rtl/heq_output_engine_if.sv
// Memory-side bus of heq_output_engine: synchronous pixel and CDF read ports plus the output write port.
interface heq_output_engine_if #(
  parameter int ADDR_W = 16,
  parameter int BUS_W  = 128
);
  logic [ADDR_W-1:0] pix_raddr;
  logic [BUS_W-1:0]  pix_rdata;
  logic [ADDR_W-1:0] cdf_raddr;
  logic [BUS_W-1:0]  cdf_rdata;
  logic              out_we;
  logic [ADDR_W-1:0] out_waddr;
  logic [BUS_W-1:0]  out_wdata;

  modport master (
    output pix_raddr, input pix_rdata,
    output cdf_raddr, input cdf_rdata,
    output out_we, output out_waddr, output out_wdata
  );

  modport slave (
    input pix_raddr, output pix_rdata,
    input cdf_raddr, output cdf_rdata,
    input out_we, input out_waddr, input out_wdata
  );
endinterface

// File: rtl/heq_output_engine.sv
// Histogram-equalisation output stage: maps each pixel word through the CDF table and writes it out.
// Optional pass-through mode is compiled in with `define HEQ_BYPASS_EN.
module heq_output_engine #(
  parameter int PIX_W    = 8,
  parameter int LANES    = 16,
  parameter int CDF_W    = 16,
  parameter int ADDR_W   = 16,
  parameter int RECIP_W  = 20,
  parameter int RECIP_SH = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  num_words,
  input  logic [ADDR_W-1:0]  src_base,
  input  logic [ADDR_W-1:0]  dst_base,
  input  logic [ADDR_W-1:0]  cdf_base,
  input  logic [CDF_W-1:0]   cdf_min,
  input  logic [RECIP_W-1:0] recip,
`ifdef HEQ_BYPASS_EN
  input  logic               bypass,
`endif
  heq_output_engine_if.master mem,
  output logic               busy,
  output logic               done
);

  localparam int BUS_W   = LANES * PIX_W;
  localparam int CPW     = BUS_W / CDF_W;
  localparam int SEL_SH  = $clog2(CPW);
  localparam int PROD_W  = CDF_W + RECIP_W;
  localparam int LANE_CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_CW-1:0] LANE_LAST = LANE_CW'(LANES - 1);
  localparam logic [PROD_W-1:0]  PIX_MAX   = PROD_W'((1 << PIX_W) - 1);

  typedef enum logic [2:0] {IDLE, RD_PIX, LOOKUP, DRAIN, WRITE, FINISH} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0]  word_idx, nwords_r, src_r, dst_r, cdfb_r;
  logic [CDF_W-1:0]   min_r;
  logic [RECIP_W-1:0] recip_r;
  logic [LANE_CW-1:0] lane_cnt;
  logic [PIX_W-1:0]   sel_r;
  logic [BUS_W-1:0]   pix_sh;
  logic [BUS_W-1:0]   result;

`ifdef HEQ_BYPASS_EN
  logic bypass_r;
`else
  localparam logic bypass_r = 1'b0;
`endif

  logic [PIX_W-1:0]  cur_pix;
  logic [CDF_W-1:0]  cdf_entry;
  logic [CDF_W-1:0]  diff;
  logic [PROD_W-1:0] prod, quo;
  logic [PIX_W-1:0]  lane_val;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (num_words == '0) ? FINISH : RD_PIX;
      RD_PIX:  state_nx = bypass_r ? WRITE : LOOKUP;
      LOOKUP:  if (lane_cnt == LANE_LAST) state_nx = DRAIN;
      DRAIN:   state_nx = WRITE;
      WRITE:   state_nx = (word_idx == nwords_r - ADDR_W'(1)) ? FINISH : RD_PIX;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Lane 0 reads the pixel word straight off the bus; later lanes use the shifted copy.
  always_comb begin
    cur_pix   = (lane_cnt == '0) ? mem.pix_rdata[PIX_W-1:0] : pix_sh[PIX_W-1:0];
    cdf_entry = CDF_W'(mem.cdf_rdata >> (int'(sel_r) * CDF_W));
    diff      = (cdf_entry >= min_r) ? cdf_entry - min_r : '0;
    prod      = PROD_W'(diff) * PROD_W'(recip_r);
    quo       = prod >> RECIP_SH;
    lane_val  = (quo > PIX_MAX) ? '1 : quo[PIX_W-1:0];
  end

  always_comb begin
    busy          = (state == RD_PIX) || (state == LOOKUP) || (state == DRAIN) || (state == WRITE);
    done          = (state == FINISH);
    mem.out_we    = (state == WRITE);
    mem.pix_raddr = (state == RD_PIX) ? src_r + word_idx : '0;
    mem.cdf_raddr = (state == LOOKUP) ? cdfb_r + ADDR_W'(cur_pix >> SEL_SH) : '0;
    mem.out_waddr = (state == WRITE) ? dst_r + word_idx : '0;
    mem.out_wdata = '0;
    if (state == WRITE) mem.out_wdata = bypass_r ? mem.pix_rdata : result;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      word_idx <= '0;
      nwords_r <= '0;
      src_r    <= '0;
      dst_r    <= '0;
      cdfb_r   <= '0;
      min_r    <= '0;
      recip_r  <= '0;
      lane_cnt <= '0;
      sel_r    <= '0;
      pix_sh   <= '0;
      result   <= '0;
`ifdef HEQ_BYPASS_EN
      bypass_r <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          nwords_r <= num_words;
          src_r    <= src_base;
          dst_r    <= dst_base;
          cdfb_r   <= cdf_base;
          min_r    <= cdf_min;
          recip_r  <= recip;
          word_idx <= '0;
          lane_cnt <= '0;
`ifdef HEQ_BYPASS_EN
          bypass_r <= bypass;
`endif
        end
        // CDF data lags its address by one cycle, so lane k-1 is retired while lane k is issued;
        // results shift in from the top so lane 0 lands at the bottom after LANES shifts.
        LOOKUP: begin
          sel_r    <= cur_pix & PIX_W'(CPW - 1);
          pix_sh   <= ((lane_cnt == '0) ? mem.pix_rdata : pix_sh) >> PIX_W;
          lane_cnt <= (lane_cnt == LANE_LAST) ? '0 : lane_cnt + LANE_CW'(1);
          if (lane_cnt != '0) result <= {lane_val, result[BUS_W-1:PIX_W]};
        end
        DRAIN: result <= {lane_val, result[BUS_W-1:PIX_W]};
        WRITE: word_idx <= word_idx + ADDR_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_heq_output_engine.sv
// Scoreboard bench for heq_output_engine: a table-based equalisation model predicts every output write.
module tb_heq_output_engine;
  localparam int PIX_W = 8, LANES = 16, CDF_W = 16, ADDR_W = 16, BUS_W = 128;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [15:0]       num_words = '0, src_base = '0, dst_base = '0, cdf_base = '0;
  logic [15:0]       cdf_min = '0;
  logic [19:0]       recip = '0;
`ifdef HEQ_BYPASS_EN
  logic              bypass = 1'b0;
`endif
  logic              busy, done;

  heq_output_engine_if #(.ADDR_W(ADDR_W), .BUS_W(BUS_W)) mem_if ();

  heq_output_engine #(
    .PIX_W(PIX_W), .LANES(LANES), .CDF_W(CDF_W), .ADDR_W(ADDR_W), .RECIP_W(20), .RECIP_SH(16)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .num_words(num_words),
    .src_base(src_base), .dst_base(dst_base), .cdf_base(cdf_base),
    .cdf_min(cdf_min), .recip(recip),
`ifdef HEQ_BYPASS_EN
    .bypass(bypass),
`endif
    .mem(mem_if), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  logic [127:0] pix_mem [0:65535];
  logic [127:0] cdf_mem [0:65535];
  int           cdf_tab [256];
  longint       jmin, jrecip;

  always @(posedge clock) begin
    mem_if.pix_rdata <= pix_mem[mem_if.pix_raddr];
    mem_if.cdf_rdata <= cdf_mem[mem_if.cdf_raddr];
  end

  logic [15:0]  exp_addr [$];
  logic [127:0] exp_data [$];
  int errors = 0, checks = 0, wr_count = 0;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Equalised value of one pixel: (max(cdf-min,0) * recip) >> 16, clipped to 255.
  function automatic logic [127:0] model_word(logic [127:0] pw);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      longint c, d, q;
      c = cdf_tab[pw[i*8 +: 8]];
      d = (c >= jmin) ? c - jmin : 0;
      q = (d * jrecip) >>> 16;
      if (q > 255) q = 255;
      r[i*8 +: 8] = 8'(q);
    end
    return r;
  endfunction

  task automatic load_cdf(input logic [15:0] base);
    for (int j = 0; j < 32; j++) begin
      logic [127:0] wv;
      for (int k = 0; k < 8; k++) wv[k*16 +: 16] = 16'(cdf_tab[j*8 + k]);
      cdf_mem[base + 16'(j)] = wv;
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && mem_if.out_we) begin
      wr_count++;
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h with nothing expected",
                 mem_if.out_waddr, mem_if.out_wdata);
      end else begin
        chk("waddr", mem_if.out_waddr, exp_addr.pop_front());
        chk("wdata", mem_if.out_wdata, exp_data.pop_front());
      end
    end
  end

  task automatic run_job(input int nw, input logic [15:0] src, input logic [15:0] dst,
                         input logic [15:0] cdfb, input int mn, input int rc, input bit byp,
                         input bit fixed, input logic [127:0] fpix, input int poke);
    int wr0, lat, exp_lat;
    bit seen;
    logic [127:0] pw;
    jmin = mn;
    jrecip = rc;
    load_cdf(cdfb);
    for (int w = 0; w < nw; w++) begin
      pw = fixed ? fpix : {$urandom(), $urandom(), $urandom(), $urandom()};
      pix_mem[src + 16'(w)] = pw;
      exp_addr.push_back(dst + 16'(w));
      exp_data.push_back(byp ? pw : model_word(pw));
    end
    exp_lat = (nw == 0) ? 1 : nw * (byp ? 2 : LANES + 3) + 1;
    wr0 = wr_count;
    @(negedge clock);
    num_words = 16'(nw); src_base = src; dst_base = dst; cdf_base = cdfb;
    cdf_min = 16'(mn); recip = 20'(rc);
`ifdef HEQ_BYPASS_EN
    bypass = byp;
`endif
    start = 1'b1;
    seen = 1'b0;
    lat = 0;
    for (int c = 1; c <= 4000 && !seen; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (c == 1) begin
        start = 1'b0;
        chk("busy_after_start", busy, (nw != 0));
      end
      if (poke != 0 && c == poke) begin
        start = 1'b1; num_words = 16'd9; dst_base = 16'h0100; src_base = 16'h0200;
        cdf_min = '0; recip = '0;
      end
      if (poke != 0 && c == poke + 1) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        lat = c;
        chk("busy_with_done", busy, 0);
      end
    end
    chk("done_seen", seen, 1);
    chk("done_latency", lat, exp_lat);
    chk("write_count", wr_count - wr0, nw);
    chk("sb_empty", exp_addr.size(), 0);
    @(posedge clock);
    @(negedge clock);
    chk("done_one_cycle", done, 0);
    exp_addr.delete();
    exp_data.delete();
  endtask

  initial begin
    logic [127:0] fp;
    int wr0, dcount;

    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", mem_if.out_we, 0);
    chk("rst_pix_raddr", mem_if.pix_raddr, 0);
    chk("rst_cdf_raddr", mem_if.cdf_raddr, 0);
    chk("rst_waddr", mem_if.out_waddr, 0);
    chk("rst_wdata", mem_if.out_wdata, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // All pixels map to cdf=64 -> every lane 0xFF.
    for (int i = 0; i < 256; i++) cdf_tab[i] = 64;
    run_job(1, 16'h0010, 16'h0020, 16'h0300, 1, 265266, 1'b0, 1'b0, '0, 0);

    // cdf=1 -> 0, cdf=0 below min -> 0, cdf=100 -> saturated.
    cdf_tab[10] = 1; cdf_tab[20] = 0; cdf_tab[30] = 100;
    for (int i = 0; i < LANES; i++) fp[i*8 +: 8] = (i % 4 == 0) ? 8'd10 : (i % 4 == 1) ? 8'd20 :
                                                  (i % 4 == 2) ? 8'd30 : 8'(i * 13);
    run_job(1, 16'h0040, 16'h0050, 16'h0700, 1, 265266, 1'b0, 1'b1, fp, 0);

    run_job(0, 16'h0000, 16'h0000, 16'h0000, 1, 265266, 1'b0, 1'b0, '0, 0);

    // Output addresses wrap; a second start mid-job is ignored.
    for (int i = 0; i < 256; i++) cdf_tab[i] = $urandom_range(0, 300);
    run_job(2, 16'hFFFF, 16'hFFFF, 16'hFFF8, 5, 265266, 1'b0, 1'b0, '0, 5);

    // Reset during LOOKUP of word 0 aborts the job silently.
    jmin = 1; jrecip = 265266;
    load_cdf(16'h1234);
    pix_mem[16'h0500] = {$urandom(), $urandom(), $urandom(), $urandom()};
    wr0 = wr_count;
    @(negedge clock);
    num_words = 16'd2; src_base = 16'h0500; dst_base = 16'h0600; cdf_base = 16'h1234;
    cdf_min = 16'd1; recip = 20'd265266; start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (c == 1) start = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_we", mem_if.out_we, 0);
    chk("abort_cdf_raddr", mem_if.cdf_raddr, 0);
    chk("abort_wdata", mem_if.out_wdata, 0);
    @(negedge clock);
    reset_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (done) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    chk("abort_no_write", wr_count - wr0, 0);

    run_job(2, 16'h0500, 16'h0600, 16'h1234, 1, 265266, 1'b0, 1'b0, '0, 0);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 256; i++) cdf_tab[i] = $urandom_range(0, 400);
      run_job($urandom_range(1, 4), 16'($urandom()), 16'($urandom()), 16'($urandom()),
              $urandom_range(0, 60), (t == 0) ? 265266 : $urandom_range(0, 1048575),
              1'b0, 1'b0, '0, 0);
    end

`ifdef HEQ_BYPASS_EN
    run_job(3, 16'h0900, 16'h0A00, 16'h0B00, 1, 265266, 1'b1, 1'b0, '0, 0);
    run_job(1, 16'h0C00, 16'h0D00, 16'h0B00, 1, 265266, 1'b0, 1'b0, '0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
